bullet_field: RTL and testbench
===============================

BULLET_FIELD -- requirements
Module: bullet_field

Interface
REQ-001 The module SHALL have parameter COLS, default 118, bullet positions per row (2..255).
REQ-002 The module SHALL have parameter ROWS, default 4, independent bullet rows (1..16).
REQ-003 The module SHALL have parameter TICK_DIV, default 50000000, clk cycles per bullet step (>=2).
REQ-004 The module SHALL have parameter COOLDOWN, default 1, steps after a shot during which further shots are rejected.
REQ-005 The module SHALL have port clk, input, 1, rising-edge clock.
REQ-006 The module SHALL have port resetn, input, 1, reset: asynchronous, active-low.
REQ-007 The module SHALL have port fire, input, 1, shoot request, sampled each cycle.
REQ-008 The module SHALL have port fire_row, input, clog2(ROWS) (min 1), row targeted by fire.
REQ-009 The module SHALL have port draw_start, input, 1, starts one scan-out pass.
REQ-010 The module SHALL have port x, output, 8, pixel column.
REQ-011 The module SHALL have port y, output, clog2(ROWS) (min 1), pixel row.
REQ-012 The module SHALL have port colour, output, 3, 3'b111 if bullet present, else 3'b000.
REQ-013 The module SHALL have port plot, output, 1, x/y/colour valid this cycle.
REQ-014 The module SHALL have port draw_busy, output, 1, scan in progress.
REQ-015 The module SHALL have port draw_done, output, 1, one-cycle end-of-scan pulse.
REQ-016 The module SHALL have port exit_pulse, output, ROWS, per-row one-cycle pulse when a bullet leaves column COLS-1.
REQ-017 The module SHALL have ports hit_valid (input, 1), hit_row (input, clog2(ROWS)) and hit_col (input, 8), bullet-clear request, present only under BULLET_FIELD_HIT_EN.

Function
REQ-018 Step counter SHALL count 0..TICK_DIV-1 and wrap; step fires in the cycle the count equals TICK_DIV-1.
REQ-019 On step, each row SHALL shift toward higher column: bit[c] <= bit[c-1], bit[0] <= pending[r], pending[r] <= 0; exit_pulse[r] SHALL be 1 for exactly that cycle if bit[COLS-1] was 1.
REQ-020 fire SHALL be accepted only when cooldown==0 and fire_row<ROWS; accepted fire sets pending[fire_row] and loads cooldown=COOLDOWN; otherwise it is ignored.
REQ-021 cooldown SHALL decrement by 1 on each executed step, saturating at 0.
REQ-022 A fire accepted in a step cycle SHALL be injected at the next step, not the current one.
REQ-023 Draw FSM SHALL have states IDLE, SCAN and DONE; draw_start is accepted only in IDLE and is ignored elsewhere.
REQ-024 In IDLE, draw_start SHALL move the FSM to SCAN with x=0, y=0.
REQ-025 In SCAN, the FSM SHALL assert plot=1 every cycle with colour from bit[y][x], then advance x, wrapping to 0 with y+1 after COLS-1.
REQ-026 After pixel (COLS-1, ROWS-1), the FSM SHALL go to DONE.
REQ-027 DONE SHALL last one cycle with draw_done=1, then return to IDLE.
REQ-028 A pass SHALL produce exactly ROWS*COLS plot cycles; the first plot SHALL occur the cycle after draw_start is accepted.
REQ-029 draw_busy SHALL be 1 in SCAN and DONE.
REQ-030 A step due while draw_busy SHALL be deferred (one-deep flag) and executed in the first IDLE cycle; the step counter keeps running; a second step during the same pass SHALL be dropped.
REQ-031 Outside SCAN, plot SHALL be 0 and x, y, colour SHALL hold their last values.

Reset
REQ-032 resetn low SHALL immediately clear all row bits, pending, cooldown, step counter and deferred-step flag, with the FSM entering IDLE.
REQ-033 resetn low SHALL immediately drive x=0, y=0, colour=0, plot=0, draw_busy=0, draw_done=0 and exit_pulse=0.
REQ-034 Reset asserted mid-scan SHALL abort the pass with no draw_done.

Configuration
REQ-035 When macro BULLET_FIELD_HIT_EN is defined, hit_valid with in-range hit_row/hit_col SHALL clear that bit in the same cycle.
REQ-036 Under BULLET_FIELD_HIT_EN, when a hit coincides with a step, the hit SHALL apply to the pre-shift bit so the cleared bullet is not propagated and raises no exit_pulse; out-of-range hits are ignored.
REQ-037 When BULLET_FIELD_HIT_EN is undefined, the hit ports SHALL be absent and bullets SHALL only leave via column COLS-1.

Verification (COLS=8, ROWS=2, TICK_DIV=4, COOLDOWN=2)
REQ-038 The bench SHALL cover: fire with fire_row=1 -> bit[1][0]=1 after the next step; after 8 steps exit_pulse=2'b10 for one cycle; the row is then empty.
REQ-039 The bench SHALL cover: fire accepted, then fire again one step later -> second shot ignored; fire after 2 steps -> accepted.
REQ-040 The bench SHALL cover: fire_row=3 -> no pending set and cooldown stays 0.
REQ-041 The bench SHALL cover: draw_start with a bullet at (x=3, y=0) -> 16 plot cycles, colour=111 only at x=3/y=0, then a draw_done pulse.
REQ-042 The bench SHALL cover: a step due during a scan -> no shift until IDLE; the shift executes in the first IDLE cycle.
REQ-043 The bench SHALL cover: resetn low mid-scan -> plot=0, draw_busy=0, all bits cleared, no draw_done; and under BULLET_FIELD_HIT_EN, a hit on (row 0, col 7) in a step cycle -> no exit_pulse.

Source files
------------

// File: rtl/bullet_field.sv
// bullet_field
//
// Holds ROWS independent rows of COLS bullet positions. Every TICK_DIV clock
// cycles the field takes one step: every bullet moves one column toward
// COLS-1, and a bullet that leaves the last column raises a one-cycle
// exit_pulse for its row. A shot is held as "pending" for its row and is
// injected at column 0 on the next step. After an accepted shot, COOLDOWN
// steps must pass before another shot is accepted. A draw pass scans the
// field out one pixel per cycle, row by row. Steps that fall due during a
// pass are deferred (at most one) until the pass has finished.
//
// Optional feature macro: BULLET_FIELD_HIT_EN
//   When defined, hit_valid/hit_row/hit_col clear a single bullet in the
//   same cycle. When undefined, these ports do not exist.
//
// Ports
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   fire        shoot request, sampled every cycle
//   fire_row    row targeted by fire
//   draw_start  starts one scan-out pass (ignored while a pass is running)
//   hit_valid   bullet-clear request        (BULLET_FIELD_HIT_EN only)
//   hit_row     row of the bullet to clear  (BULLET_FIELD_HIT_EN only)
//   hit_col     column of the bullet to clear (BULLET_FIELD_HIT_EN only)
//   x, y        pixel column / row of the current scan-out pixel
//   colour      3'b111 when a bullet is present at (x, y), else 3'b000
//   plot        x/y/colour valid this cycle
//   draw_busy   scan pass in progress (including its done cycle)
//   draw_done   one-cycle pulse at the end of a pass
//   exit_pulse  per-row one-cycle pulse when a bullet leaves column COLS-1

module bullet_field #(
    parameter int COLS     = 118,
    parameter int ROWS     = 4,
    parameter int TICK_DIV = 50000000,
    parameter int COOLDOWN = 1,
    localparam int RW      = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            fire,
    input  logic [RW-1:0]   fire_row,
    input  logic            draw_start,
`ifdef BULLET_FIELD_HIT_EN
    input  logic            hit_valid,
    input  logic [RW-1:0]   hit_row,
    input  logic [7:0]      hit_col,
`endif
    output logic [7:0]      x,
    output logic [RW-1:0]   y,
    output logic [2:0]      colour,
    output logic            plot,
    output logic            draw_busy,
    output logic            draw_done,
    output logic [ROWS-1:0] exit_pulse
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int CD_W  = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                     state;
    logic [ROWS-1:0][COLS-1:0]  bits_q;
    logic [ROWS-1:0][COLS-1:0]  live_bits;
    logic [ROWS-1:0][COLS-1:0]  bits_next;
    logic [ROWS-1:0]            pending_q;
    logic [ROWS-1:0]            pending_next;
    logic [CD_W-1:0]            cooldown_q;
    logic [CD_W-1:0]            cooldown_next;
    logic [CNT_W-1:0]           step_cnt;
    logic                       deferred_q;
    logic                       tick;
    logic                       do_step;
    logic                       fire_ok;
    logic                       scan_last;
    logic [7:0]                 next_x;
    logic [RW-1:0]              next_y;
    logic [COLS-1:0]            sel_row;
    logic                       next_pix;

    assign tick    = (step_cnt == CNT_W'(TICK_DIV - 1));
    // A step only ever executes while idle: either the one due right now or
    // the single one that was deferred during the last draw pass.
    assign do_step = (state == IDLE) && (tick || deferred_q);
    assign fire_ok = fire && (cooldown_q == '0) && (int'(fire_row) < ROWS);

    // Field as seen by this cycle's step: a hit clears the bullet before it
    // would be shifted, so it neither propagates nor raises an exit pulse.
    always_comb begin
        live_bits = bits_q;
`ifdef BULLET_FIELD_HIT_EN
        if (hit_valid) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    if (int'(hit_row) == r && int'(hit_col) == c) begin
                        live_bits[r][c] = 1'b0;
                    end
                end
            end
        end
`endif
    end

    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            exit_pulse[r] = do_step & live_bits[r][COLS-1];
        end
    end

    // A shot accepted in a step cycle sets pending after the step has
    // consumed the old pending bit, so it is injected on the next step.
    always_comb begin
        bits_next     = live_bits;
        pending_next  = pending_q;
        cooldown_next = cooldown_q;
        if (do_step) begin
            for (int r = 0; r < ROWS; r++) begin
                bits_next[r] = {live_bits[r][COLS-2:0], pending_q[r]};
            end
            pending_next = '0;
            if (cooldown_q != '0) begin
                cooldown_next = cooldown_q - CD_W'(1);
            end
        end
        if (fire_ok) begin
            for (int r = 0; r < ROWS; r++) begin
                if (int'(fire_row) == r) begin
                    pending_next[r] = 1'b1;
                end
            end
            cooldown_next = CD_W'(COOLDOWN);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bits_q     <= '0;
            pending_q  <= '0;
            cooldown_q <= '0;
            step_cnt   <= '0;
            deferred_q <= 1'b0;
        end else begin
            step_cnt <= tick ? '0 : step_cnt + CNT_W'(1);
            // One-deep: further steps due in the same pass are dropped.
            if (state != IDLE) begin
                if (tick) begin
                    deferred_q <= 1'b1;
                end
            end else begin
                deferred_q <= 1'b0;
            end
            bits_q     <= bits_next;
            pending_q  <= pending_next;
            cooldown_q <= cooldown_next;
        end
    end

    // Next scan pixel and its bullet bit.
    always_comb begin
        scan_last = (x == 8'(COLS - 1)) && (int'(y) == ROWS - 1);
        if (x == 8'(COLS - 1)) begin
            next_x = '0;
            next_y = y + RW'(1);
        end else begin
            next_x = x + 8'd1;
            next_y = y;
        end
        sel_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(next_y) == r) begin
                sel_row = bits_q[r];
            end
        end
        next_pix = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(next_x) == c) begin
                next_pix = sel_row[c];
            end
        end
    end

    // Outputs are registered: the pixel loaded on an edge is presented for
    // the whole following cycle, so the first plot appears the cycle after
    // draw_start is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            x         <= '0;
            y         <= '0;
            colour    <= '0;
            plot      <= 1'b0;
            draw_busy <= 1'b0;
            draw_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (draw_start) begin
                        state     <= SCAN;
                        x         <= '0;
                        y         <= '0;
                        colour    <= bits_q[0][0] ? 3'b111 : 3'b000;
                        plot      <= 1'b1;
                        draw_busy <= 1'b1;
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        state     <= DONE;
                        plot      <= 1'b0;
                        draw_done <= 1'b1;
                    end else begin
                        x      <= next_x;
                        y      <= next_y;
                        colour <= next_pix ? 3'b111 : 3'b000;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    draw_done <= 1'b0;
                    draw_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bullet_field.sv
// tb_bullet_field
//
// Drives bullet_field (COLS=8, ROWS=2, TICK_DIV=4, COOLDOWN=2) with directed
// scenarios and a randomized phase, and compares every output every cycle
// against a behavioural model of the field kept as plain arrays and a
// linear pixel index. A second instance with ROWS=3 gives a 2-bit fire_row
// so that an out-of-range row (3) can be presented.
// Define BULLET_FIELD_HIT_EN to also exercise the hit ports.

module tb_bullet_field;

    localparam int COLS     = 8;
    localparam int ROWS     = 2;
    localparam int TICK_DIV = 4;
    localparam int COOLDOWN = 2;
    localparam int NPIX     = COLS * ROWS;

    logic        clk = 1'b0;
    logic        resetn;
    logic        fire;
    logic [0:0]  fireRow;
    logic        drawStart;
    logic        hitValid;
    logic [0:0]  hitRow;
    logic [7:0]  hitCol;
    logic [7:0]  x;
    logic [0:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        drawBusy;
    logic        drawDone;
    logic [1:0]  exitPulse;

    logic        fire3;
    logic [1:0]  fireRow3;
    logic [7:0]  x3;
    logic [1:0]  y3;
    logic [2:0]  colour3;
    logic        plot3;
    logic        busy3;
    logic        done3;
    logic [2:0]  exit3;

    int nChecks = 0;
    int nErrors = 0;

    // Behavioural model state
    bit       mField [ROWS][COLS];
    bit       mPend  [ROWS];
    int       mCool;
    int       mCnt;
    int       mScan;          // -1 idle, 0..NPIX-1 pixel shown, NPIX done cycle
    int       mSteps;         // executed steps since time zero
    bit       mDeferred;
    int       mX;
    int       mY;
    bit [2:0] mColour;

    // Image captured by doScan
    bit scanImg [ROWS][COLS];
    int scanPlots;
    int scanDones;
    int scanLit;

    always #5 clk = ~clk;

    bullet_field #(
        .COLS(COLS), .ROWS(ROWS), .TICK_DIV(TICK_DIV), .COOLDOWN(COOLDOWN)
    ) u_dut (
        .clk(clk),
        .resetn(resetn),
        .fire(fire),
        .fire_row(fireRow),
        .draw_start(drawStart),
`ifdef BULLET_FIELD_HIT_EN
        .hit_valid(hitValid),
        .hit_row(hitRow),
        .hit_col(hitCol),
`endif
        .x(x),
        .y(y),
        .colour(colour),
        .plot(plot),
        .draw_busy(drawBusy),
        .draw_done(drawDone),
        .exit_pulse(exitPulse)
    );

    bullet_field #(
        .COLS(COLS), .ROWS(3), .TICK_DIV(TICK_DIV), .COOLDOWN(COOLDOWN)
    ) u_dut3 (
        .clk(clk),
        .resetn(resetn),
        .fire(fire3),
        .fire_row(fireRow3),
        .draw_start(1'b0),
`ifdef BULLET_FIELD_HIT_EN
        .hit_valid(1'b0),
        .hit_row(2'b00),
        .hit_col(8'd0),
`endif
        .x(x3),
        .y(y3),
        .colour(colour3),
        .plot(plot3),
        .draw_busy(busy3),
        .draw_done(done3),
        .exit_pulse(exit3)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int r = 0; r < ROWS; r++) begin
            mPend[r] = 1'b0;
            for (int c = 0; c < COLS; c++) mField[r][c] = 1'b0;
        end
        mCool     = 0;
        mCnt      = 0;
        mScan     = -1;
        mDeferred = 1'b0;
        mX        = 0;
        mY        = 0;
        mColour   = 3'b000;
    endtask

    function automatic bit modelStepDue();
        return (mScan < 0) && ((mCnt == TICK_DIV - 1) || mDeferred);
    endfunction

    function automatic bit modelHitAt(int r, int c);
        return hitValid && (int'(hitRow) == r) && (int'(hitCol) == c);
    endfunction

    task automatic loadPixel(input int k);
        mX      = k % COLS;
        mY      = k / COLS;
        mColour = mField[mY][mX] ? 3'b111 : 3'b000;
    endtask

    // One clock edge of the model, computed from the state before the edge.
    task automatic modelAdvance();
        bit step;
        bit tickNow;
        bit busyBefore;
        int oldCool;
        step       = modelStepDue();
        tickNow    = (mCnt == TICK_DIV - 1);
        busyBefore = (mScan >= 0);
        oldCool    = mCool;

        if (mScan < 0) begin
            if (drawStart) begin
                mScan = 0;
                loadPixel(0);
            end
        end else if (mScan < NPIX - 1) begin
            mScan++;
            loadPixel(mScan);
        end else if (mScan == NPIX - 1) begin
            mScan = NPIX;
        end else begin
            mScan = -1;
        end

        if (busyBefore) begin
            if (tickNow) mDeferred = 1'b1;
        end else begin
            mDeferred = 1'b0;
        end

        if (hitValid && int'(hitRow) < ROWS && int'(hitCol) < COLS) mField[hitRow][hitCol] = 1'b0;

        if (step) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = COLS - 1; c > 0; c--) mField[r][c] = mField[r][c-1];
                mField[r][0] = mPend[r];
                mPend[r]     = 1'b0;
            end
            if (mCool > 0) mCool--;
            mSteps++;
        end

        if (fire && oldCool == 0 && int'(fireRow) < ROWS) begin
            mPend[fireRow] = 1'b1;
            mCool          = COOLDOWN;
        end

        mCnt = (mCnt + 1) % TICK_DIV;
    endtask

    always @(posedge clk) begin
        if (resetn) modelAdvance();
    end

    task automatic checkAll();
        logic [1:0] expExit;
        for (int r = 0; r < ROWS; r++) begin
            expExit[r] = modelStepDue() && mField[r][COLS-1] && !modelHitAt(r, COLS - 1);
        end
        checkOutput("x", 32'(x), 32'(mX));
        checkOutput("y", 32'(y), 32'(mY));
        checkOutput("colour", 32'(colour), 32'(mColour));
        checkOutput("plot", 32'(plot), 32'((mScan >= 0) && (mScan < NPIX)));
        checkOutput("draw_busy", 32'(drawBusy), 32'(mScan >= 0));
        checkOutput("draw_done", 32'(drawDone), 32'(mScan == NPIX));
        checkOutput("exit_pulse", 32'(exitPulse), 32'(expExit));
    endtask

    // Drive inputs at the falling edge, let one rising edge pass, then check.
    task automatic applyStimulus(input bit f, input int fr, input bit ds,
                                 input bit hv, input int hr, input int hc);
        fire      = f;
        fireRow   = 1'(fr);
        drawStart = ds;
        hitValid  = hv;
        hitRow    = 1'(hr);
        hitCol    = 8'(hc);
        @(posedge clk);
        @(negedge clk);
        checkAll();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic waitSteps(input int n);
        int target;
        target = mSteps + n;
        for (int i = 0; i < n * TICK_DIV * 20 && mSteps < target; i++) applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        resetn = 1'b0;
        modelReset();
        #1;
        checkAll();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        resetn = 1'b1;
    endtask

    // Runs one draw pass and captures the image; ends on the draw_done cycle.
    task automatic doScan();
        bit sawDone;
        sawDone   = 1'b0;
        scanPlots = 0;
        scanDones = 0;
        scanLit   = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) scanImg[r][c] = 1'b0;
        applyStimulus(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < NPIX + 20 && !sawDone; i++) begin
            if (plot) begin
                scanPlots++;
                if (colour == 3'b111) begin
                    scanLit++;
                    if (int'(y) < ROWS && int'(x) < COLS) scanImg[y][x] = 1'b1;
                end
            end
            if (drawDone) begin
                scanDones++;
                sawDone = 1'b1;
            end else begin
                applyStimulus(0, 0, 0, 0, 0, 0);
            end
        end
        checkOutput("scan_done_seen", 32'(sawDone), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int others;
        int stepsAtExit;
        int s0;
        logic [1:0] exitVal;
        bit hv;

        resetn    = 1'b0;
        fire      = 1'b0;
        fireRow   = '0;
        drawStart = 1'b0;
        hitValid  = 1'b0;
        hitRow    = '0;
        hitCol    = '0;
        fire3     = 1'b0;
        fireRow3  = '0;
        mSteps    = 0;
        modelReset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_x", 32'(x), 32'd0);
        checkOutput("reset_y", 32'(y), 32'd0);
        checkOutput("reset_colour", 32'(colour), 32'd0);
        checkOutput("reset_plot", 32'(plot), 32'd0);
        checkOutput("reset_busy", 32'(drawBusy), 32'd0);
        checkOutput("reset_done", 32'(drawDone), 32'd0);
        checkOutput("reset_exit", 32'(exitPulse), 32'd0);
        checkAll();
        resetn = 1'b1;

        // Out-of-range row on the ROWS=3 instance must not load cooldown
        fire3    = 1'b1;
        fireRow3 = 2'd3;
        idle(1);
        fireRow3 = 2'd0;
        idle(1);
        fire3    = 1'b0;
        pulses   = 0;
        others   = 0;
        for (int i = 0; i < 60; i++) begin
            if (exit3 == 3'b001) pulses++;
            else if (exit3 != 3'b000) others++;
            idle(1);
        end
        checkOutput("row3_ignored_row0_exits", 32'(pulses), 32'd1);
        checkOutput("row3_no_other_exit", 32'(others), 32'd0);

        // Fire into row 1, watch it appear, travel and leave
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        waitSteps(1);
        s0 = mSteps;
        doScan();
        checkOutput("inject_bit_1_0", 32'(scanImg[1][0]), 32'd1);
        checkOutput("inject_lit", 32'(scanLit), 32'd1);
        pulses      = 0;
        others      = 0;
        stepsAtExit = -1;
        exitVal     = '0;
        for (int i = 0; i < 80; i++) begin
            if (exitPulse != 2'b00) begin
                if (pulses == 0) begin
                    exitVal     = exitPulse;
                    stepsAtExit = mSteps - s0 + 1;
                end
                pulses++;
            end
            idle(1);
        end
        checkOutput("exit_once", 32'(pulses), 32'd1);
        checkOutput("exit_value", 32'(exitVal), 32'b10);
        checkOutput("exit_after_8_steps", 32'(stepsAtExit), 32'd8);
        idle(1);
        doScan();
        checkOutput("row_empty_after_exit", 32'(scanLit), 32'd0);

        // Cooldown: second shot one step later rejected, after two accepted
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitSteps(1);
        applyStimulus(1, 1, 0, 0, 0, 0);
        waitSteps(1);
        applyStimulus(1, 1, 0, 0, 0, 0);
        waitSteps(1);
        doScan();
        checkOutput("cooldown_lit", 32'(scanLit), 32'd2);
        checkOutput("cooldown_row0_col2", 32'(scanImg[0][2]), 32'd1);
        checkOutput("cooldown_row1_col0", 32'(scanImg[1][0]), 32'd1);

        // Full scan with a bullet at (3,0), then deferred step on return to idle
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitSteps(4);
        doScan();
        checkOutput("scan_plots", 32'(scanPlots), 32'd16);
        checkOutput("scan_done_pulses", 32'(scanDones), 32'd1);
        checkOutput("scan_lit", 32'(scanLit), 32'd1);
        checkOutput("scan_bullet_3_0", 32'(scanImg[0][3]), 32'd1);
        idle(1);
        checkOutput("idle_after_done_busy", 32'(drawBusy), 32'd0);
        doScan();
        checkOutput("deferred_lit", 32'(scanLit), 32'd1);
        checkOutput("deferred_bullet_4_0", 32'(scanImg[0][4]), 32'd1);

        // Reset in the middle of a pass
        doReset();
        applyStimulus(1, 1, 0, 0, 0, 0);
        waitSteps(2);
        applyStimulus(0, 0, 1, 0, 0, 0);
        idle(4);
        resetn = 1'b0;
        modelReset();
        #1;
        checkOutput("midscan_rst_plot", 32'(plot), 32'd0);
        checkOutput("midscan_rst_busy", 32'(drawBusy), 32'd0);
        checkAll();
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (drawDone) pulses++;
            idle(1);
        end
        checkOutput("midscan_no_done", 32'(pulses), 32'd0);
        doScan();
        checkOutput("midscan_bits_cleared", 32'(scanLit), 32'd0);

`ifdef BULLET_FIELD_HIT_EN
        // Hit on (row 0, col 7) in the very cycle the bullet would exit
        doReset();
        applyStimulus(1, 0, 0, 0, 0, 0);
        waitSteps(8);
        for (int i = 0; i < 2 * TICK_DIV && !modelStepDue(); i++) idle(1);
        checkOutput("hit_bullet_at_col7", 32'(mField[0][COLS-1]), 32'd1);
        hitValid = 1'b1;
        hitRow   = 1'b0;
        hitCol   = 8'd7;
        #1;
        checkOutput("hit_exit_suppressed", 32'(exitPulse), 32'd0);
        applyStimulus(0, 0, 0, 1, 0, 7);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (exitPulse != 2'b00) pulses++;
            idle(1);
        end
        checkOutput("hit_no_later_exit", 32'(pulses), 32'd0);
        doScan();
        checkOutput("hit_field_empty", 32'(scanLit), 32'd0);
`endif

        // Randomized phase against the model
        idle(1);
        for (int i = 0; i < 2500; i++) begin
            hv = 1'b0;
`ifdef BULLET_FIELD_HIT_EN
            hv = ($urandom_range(0, 7) == 0);
`endif
            if ($urandom_range(0, 799) == 0) begin
                doReset();
            end else begin
                applyStimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 1)),
                              $urandom_range(0, 29) == 0, hv,
                              int'($urandom_range(0, 1)), int'($urandom_range(0, 11)));
            end
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
